// File: rtl/countdown_sched_if.sv
// countdown_sched_if -- request/response bundle for countdown_sched.
//   master : drives tick / lockout request / user alarm controls, observes counter.
//   slave  : countdown_sched itself.
//   Inputs to the block : tick, lk_req, usr_load, usr_val[27:0], usr_start, usr_abort
//   Outputs of the block: cnt_val[27:0], owner, st[1:0], usr_ack, usr_nack,
//                         usr_done, lk_done
interface countdown_sched_if;
    logic        tick;
    logic        lk_req;
    logic        usr_load;
    logic [27:0] usr_val;
    logic        usr_start;
    logic        usr_abort;
    logic [27:0] cnt_val;
    logic        owner;
    logic [1:0]  st;
    logic        usr_ack;
    logic        usr_nack;
    logic        usr_done;
    logic        lk_done;

    modport master (
        output tick, lk_req, usr_load, usr_val, usr_start, usr_abort,
        input  cnt_val, owner, st, usr_ack, usr_nack, usr_done, lk_done
    );

    modport slave (
        input  tick, lk_req, usr_load, usr_val, usr_start, usr_abort,
        output cnt_val, owner, st, usr_ack, usr_nack, usr_done, lk_done
    );
endinterface

// File: rtl/countdown_sched.sv
// countdown_sched -- shared BCD countdown arbitrated between a user alarm and
// a password lockout. The lockout preempts the user alarm, parking its value
// in a save register, and hands it back when the lockout expires.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : countdown_sched_if.slave (controls in, counter/state/pulses out)
// Counter format: 7 BCD nibbles d6..d0 = 10h, h, 10min, min, 10s, s, tenths.
module countdown_sched #(
    parameter logic [27:0] LOCK_PRESET = 28'h0001000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    countdown_sched_if.slave      bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN_U = 2'd2,
        S_RUN_L = 2'd3
    } state_t;

    // BCD decrement by one tenth; caller guarantees v != 0 so d6 never borrows.
    function automatic logic [27:0] bcd_dec(input logic [27:0] v);
        logic [27:0] r;
        logic        borrow;
        logic [3:0]  d;
        logic [3:0]  dmax;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 7; i++) begin
            d    = v[i*4 +: 4];
            dmax = (i == 2 || i == 4) ? 4'd5 : 4'd9;
            if (borrow) begin
                if (d != 4'd0) begin
                    r[i*4 +: 4] = d - 4'd1;
                    borrow      = 1'b0;
                end else if (i != 6) begin
                    r[i*4 +: 4] = dmax;
                end
            end
        end
        return r;
    endfunction

    function automatic logic bcd_ok(input logic [27:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (v[i*4 +: 4] > ((i == 2 || i == 4) ? 4'd5 : 4'd9))
                ok = 1'b0;
        end
        return ok;
    endfunction

    state_t      r_st;
    logic [27:0] r_cnt;
    logic        r_owner;
    logic [27:0] r_saved;
    logic        r_saved_valid;
    logic        r_saved_armed;
    logic        r_usr_ack;
    logic        r_usr_nack;
    logic        r_usr_done;
    logic        r_lk_done;

    logic [27:0] w_dec;
    logic        w_load_ok;
    logic        w_run_expire;

    assign w_dec     = bcd_dec(r_cnt);
    assign w_load_ok = bcd_ok(bus.usr_val);
    // A running state with a zero count (e.g. LOCK_PRESET of 0) expires at once.
    assign w_run_expire = (r_cnt == '0) || (bus.tick && (w_dec == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st          <= S_IDLE;
            r_cnt         <= '0;
            r_owner       <= 1'b0;
            r_saved       <= '0;
            r_saved_valid <= 1'b0;
            r_saved_armed <= 1'b0;
            r_usr_ack     <= 1'b0;
            r_usr_nack    <= 1'b0;
            r_usr_done    <= 1'b0;
            r_lk_done     <= 1'b0;
        end else begin
            r_usr_ack  <= 1'b0;
            r_usr_nack <= 1'b0;
            r_usr_done <= 1'b0;
            r_lk_done  <= 1'b0;
            case (r_st)
                S_IDLE: begin
                    if (bus.lk_req) begin
                        r_st          <= S_RUN_L;
                        r_owner       <= 1'b1;
                        r_cnt         <= LOCK_PRESET;
                        r_saved_valid <= 1'b0;
                        r_usr_nack    <= bus.usr_load;
                    end else if (bus.usr_load) begin
                        // usr_start in the same cycle is dropped: load wins.
                        if (w_load_ok) begin
                            r_st      <= S_ARMED;
                            r_cnt     <= bus.usr_val;
                            r_usr_ack <= 1'b1;
                        end else begin
                            r_usr_nack <= 1'b1;
                        end
                    end
                end
                S_ARMED: begin
                    if (bus.lk_req) begin
                        // Park the armed value; a coincident abort discards it.
                        r_saved       <= r_cnt;
                        r_saved_armed <= 1'b1;
                        r_saved_valid <= !bus.usr_abort;
                        r_st          <= S_RUN_L;
                        r_owner       <= 1'b1;
                        r_cnt         <= LOCK_PRESET;
                        r_usr_nack    <= bus.usr_load;
                    end else if (bus.usr_abort) begin
                        r_st       <= S_IDLE;
                        r_cnt      <= '0;
                        r_usr_nack <= bus.usr_load;
                    end else if (bus.usr_load) begin
                        if (w_load_ok) begin
                            r_cnt     <= bus.usr_val;
                            r_usr_ack <= 1'b1;
                        end else begin
                            r_usr_nack <= 1'b1;
                        end
                    end else if (bus.usr_start) begin
                        if (r_cnt == '0) begin
                            r_st       <= S_IDLE;
                            r_usr_done <= 1'b1;
                        end else begin
                            r_st <= S_RUN_U;
                        end
                    end
                end
                S_RUN_U: begin
                    r_usr_nack <= bus.usr_load;
                    if (bus.lk_req) begin
                        // Save the unticked value: a same-cycle tick is dropped.
                        r_saved       <= r_cnt;
                        r_saved_armed <= 1'b0;
                        r_saved_valid <= !bus.usr_abort;
                        r_st          <= S_RUN_L;
                        r_owner       <= 1'b1;
                        r_cnt         <= LOCK_PRESET;
                    end else if (bus.usr_abort) begin
                        r_st  <= S_IDLE;
                        r_cnt <= '0;
                    end else if (w_run_expire) begin
                        r_st       <= S_IDLE;
                        r_cnt      <= '0;
                        r_usr_done <= 1'b1;
                    end else if (bus.tick) begin
                        r_cnt <= w_dec;
                    end
                end
                S_RUN_L: begin
                    r_usr_nack <= bus.usr_load;
                    if (bus.usr_abort)
                        r_saved_valid <= 1'b0;
                    if (w_run_expire) begin
                        r_lk_done     <= 1'b1;
                        r_owner       <= 1'b0;
                        r_saved_valid <= 1'b0;
                        if (r_saved_valid && !bus.usr_abort) begin
                            r_cnt <= r_saved;
                            r_st  <= r_saved_armed ? S_ARMED : S_RUN_U;
                        end else begin
                            r_cnt <= '0;
                            r_st  <= S_IDLE;
                        end
                    end else if (bus.tick) begin
                        r_cnt <= w_dec;
                    end
                end
                default: begin
                    r_st    <= S_IDLE;
                    r_cnt   <= '0;
                    r_owner <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cnt_val  = r_cnt;
    assign bus.owner    = r_owner;
    assign bus.st       = r_st;
    assign bus.usr_ack  = r_usr_ack;
    assign bus.usr_nack = r_usr_nack;
    assign bus.usr_done = r_usr_done;
    assign bus.lk_done  = r_lk_done;

endmodule

// File: tb/tb_countdown_sched.sv
module tb_countdown_sched;
    localparam logic [27:0] PRE   = 28'h0001000;
    localparam logic [1:0]  IDLE  = 2'd0;
    localparam logic [1:0]  ARMED = 2'd1;
    localparam logic [1:0]  RUN_U = 2'd2;
    localparam logic [1:0]  RUN_L = 2'd3;

    logic clk;
    logic rst_n;
    countdown_sched_if bus();

    countdown_sched #(.LOCK_PRESET(PRE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  st;
        logic [27:0] cnt;
        logic        own, ack, nack, ud, ldn;
    } exp_t;

    typedef struct {
        logic        tk, lk, ld;
        logic [27:0] val;
        logic        sta, ab;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    function automatic exp_t mk(logic [1:0] st, logic [27:0] cnt,
                                logic own, logic ack, logic nack, logic ud, logic ldn);
        exp_t e;
        e.st = st; e.cnt = cnt; e.own = own; e.ack = ack; e.nack = nack; e.ud = ud; e.ldn = ldn;
        return e;
    endfunction

    function automatic vec_t mkv(logic tk, logic lk, logic ld, logic [27:0] val,
                                 logic sta, logic ab, exp_t e);
        vec_t v;
        v.tk = tk; v.lk = lk; v.ld = ld; v.val = val; v.sta = sta; v.ab = ab; v.e = e;
        return v;
    endfunction

    // Tenths of a second -> 7-digit BCD, built by division rather than borrow.
    function automatic logic [27:0] to_bcd(int t);
        int s, m, h;
        s = t / 10; m = s / 60; h = m / 60;
        return {4'(h / 10 % 10), 4'(h % 10), 4'(m / 10 % 6), 4'(m % 10),
                4'(s / 10 % 6), 4'(s % 10), 4'(t % 10)};
    endfunction

    task automatic chk(input string nm, input logic [27:0] act, input logic [27:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    endtask

    task automatic check_obs(input string tag, input exp_t e);
        chk({tag, ".st"},       28'(bus.st),       28'(e.st));
        chk({tag, ".cnt"},      bus.cnt_val,       e.cnt);
        chk({tag, ".owner"},    28'(bus.owner),    28'(e.own));
        chk({tag, ".usr_ack"},  28'(bus.usr_ack),  28'(e.ack));
        chk({tag, ".usr_nack"}, 28'(bus.usr_nack), 28'(e.nack));
        chk({tag, ".usr_done"}, 28'(bus.usr_done), 28'(e.ud));
        chk({tag, ".lk_done"},  28'(bus.lk_done),  28'(e.ldn));
    endtask

    task automatic clear_in();
        bus.tick = 1'b0; bus.lk_req = 1'b0; bus.usr_load = 1'b0;
        bus.usr_val = '0; bus.usr_start = 1'b0; bus.usr_abort = 1'b0;
    endtask

    // Drive one cycle; expected result is queued at drive time and checked
    // once the registered outputs settle after the edge.
    task automatic step(input string tag, input logic tk, input logic lk, input logic ld,
                        input logic [27:0] v, input logic sta, input logic ab, input exp_t e);
        exp_t x;
        bus.tick = tk; bus.lk_req = lk; bus.usr_load = ld;
        bus.usr_val = v; bus.usr_start = sta; bus.usr_abort = ab;
        sb.push_back(e);
        @(posedge clk); #1;
        clear_in();
        if (sb.size() == 0) begin
            n_tot++;
            $display("FAIL %s.scoreboard: got empty queue want entry", tag);
        end else begin
            x = sb.pop_front();
            check_obs(tag, x);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_obs(tag, mk(IDLE, '0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // 600 ticks of lockout from PRE, ending in (fin_st, fin_cnt) with lk_done.
    task automatic lock_run(input string tag, input logic [1:0] fin_st, input logic [27:0] fin_cnt);
        for (int k = 1; k <= 600; k++) begin
            if (k < 600)
                step($sformatf("%s.t%0d", tag, k), 1, 0, 0, '0, 0, 0,
                     mk(RUN_L, to_bcd(600 - k), 1, 0, 0, 0, 0));
            else
                step($sformatf("%s.t%0d", tag, k), 1, 0, 0, '0, 0, 0,
                     mk(fin_st, fin_cnt, 0, 0, 0, 0, 1));
        end
    endtask

    vec_t tbl[24];

    initial begin
        tbl[0]  = mkv(0, 0, 0, '0,          0, 0, mk(IDLE,  '0,          0, 0, 0, 0, 0));
        tbl[1]  = mkv(1, 0, 0, '0,          0, 0, mk(IDLE,  '0,          0, 0, 0, 0, 0));
        tbl[2]  = mkv(0, 0, 1, 28'h0000A00, 0, 0, mk(IDLE,  '0,          0, 0, 1, 0, 0));
        tbl[3]  = mkv(0, 0, 1, 28'h0010000, 1, 0, mk(ARMED, 28'h0010000, 0, 1, 0, 0, 0));
        tbl[4]  = mkv(0, 0, 1, 28'h0000060, 0, 0, mk(ARMED, 28'h0000060, 0, 1, 0, 0, 0));
        tbl[5]  = mkv(1, 0, 0, '0,          0, 0, mk(ARMED, 28'h0000060, 0, 0, 0, 0, 0));
        tbl[6]  = mkv(0, 0, 1, 28'h0000A00, 0, 0, mk(ARMED, 28'h0000060, 0, 0, 1, 0, 0));
        tbl[7]  = mkv(0, 0, 0, '0,          0, 1, mk(IDLE,  '0,          0, 0, 0, 0, 0));
        tbl[8]  = mkv(0, 0, 1, 28'h0010000, 0, 0, mk(ARMED, 28'h0010000, 0, 1, 0, 0, 0));
        tbl[9]  = mkv(0, 0, 0, '0,          1, 0, mk(RUN_U, 28'h0010000, 0, 0, 0, 0, 0));
        tbl[10] = mkv(1, 0, 0, '0,          0, 0, mk(RUN_U, 28'h0009599, 0, 0, 0, 0, 0));
        tbl[11] = mkv(0, 0, 1, 28'h0000005, 0, 0, mk(RUN_U, 28'h0009599, 0, 0, 1, 0, 0));
        tbl[12] = mkv(0, 0, 0, '0,          0, 1, mk(IDLE,  '0,          0, 0, 0, 0, 0));
        tbl[13] = mkv(0, 0, 1, 28'h0000002, 0, 0, mk(ARMED, 28'h0000002, 0, 1, 0, 0, 0));
        tbl[14] = mkv(0, 0, 0, '0,          1, 0, mk(RUN_U, 28'h0000002, 0, 0, 0, 0, 0));
        tbl[15] = mkv(1, 0, 0, '0,          0, 0, mk(RUN_U, 28'h0000001, 0, 0, 0, 0, 0));
        tbl[16] = mkv(0, 0, 0, '0,          0, 0, mk(RUN_U, 28'h0000001, 0, 0, 0, 0, 0));
        tbl[17] = mkv(1, 0, 0, '0,          0, 0, mk(IDLE,  '0,          0, 0, 0, 1, 0));
        tbl[18] = mkv(0, 0, 0, '0,          0, 0, mk(IDLE,  '0,          0, 0, 0, 0, 0));
        tbl[19] = mkv(0, 0, 1, '0,          0, 0, mk(ARMED, '0,          0, 1, 0, 0, 0));
        tbl[20] = mkv(0, 0, 0, '0,          1, 0, mk(IDLE,  '0,          0, 0, 0, 1, 0));
        tbl[21] = mkv(0, 1, 1, 28'h0000005, 0, 0, mk(RUN_L, PRE,         1, 0, 1, 0, 0));
        tbl[22] = mkv(1, 1, 0, '0,          0, 0, mk(RUN_L, 28'h0000599, 1, 0, 0, 0, 0));
        tbl[23] = mkv(0, 0, 1, 28'h0000005, 0, 0, mk(RUN_L, 28'h0000599, 1, 0, 1, 0, 0));

        clear_in();
        rst_n = 1'b0;
        #12;
        check_obs("reset", mk(IDLE, '0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++)
            step($sformatf("row%0d", i), tbl[i].tk, tbl[i].lk, tbl[i].ld, tbl[i].val,
                 tbl[i].sta, tbl[i].ab, tbl[i].e);

        // Full lockout from IDLE, back to IDLE with a single-cycle lk_done.
        do_reset("rstA");
        step("A.lk", 0, 1, 0, '0, 0, 0, mk(RUN_L, PRE, 1, 0, 0, 0, 0));
        lock_run("A", IDLE, '0);
        step("A.after", 0, 0, 0, '0, 0, 0, mk(IDLE, '0, 0, 0, 0, 0, 0));

        // Preempt a running alarm on a tick; the saved value is unticked.
        do_reset("rstB");
        step("B.load",  0, 0, 1, 28'h0000050, 0, 0, mk(ARMED, 28'h0000050, 0, 1, 0, 0, 0));
        step("B.start", 0, 0, 0, '0,          1, 0, mk(RUN_U, 28'h0000050, 0, 0, 0, 0, 0));
        step("B.lk",    1, 1, 0, '0,          0, 0, mk(RUN_L, PRE,         1, 0, 0, 0, 0));
        lock_run("B", RUN_U, 28'h0000050);
        step("B.tick",  1, 0, 0, '0,          0, 0, mk(RUN_U, 28'h0000049, 0, 0, 0, 0, 0));

        // Abort during lockout drops the saved alarm but lockout continues.
        do_reset("rstC");
        step("C.load",  0, 0, 1, 28'h0000050, 0, 0, mk(ARMED, 28'h0000050, 0, 1, 0, 0, 0));
        step("C.start", 0, 0, 0, '0,          1, 0, mk(RUN_U, 28'h0000050, 0, 0, 0, 0, 0));
        step("C.lk",    0, 1, 0, '0,          0, 0, mk(RUN_L, PRE,         1, 0, 0, 0, 0));
        step("C.abort", 0, 0, 0, '0,          0, 1, mk(RUN_L, PRE,         1, 0, 0, 0, 0));
        lock_run("C", IDLE, '0);
        step("C.after", 0, 0, 0, '0,          0, 0, mk(IDLE, '0,           0, 0, 0, 0, 0));

        // Preempt from ARMED returns to ARMED, then the alarm can start.
        do_reset("rstD");
        step("D.load",  0, 0, 1, 28'h0000123, 0, 0, mk(ARMED, 28'h0000123, 0, 1, 0, 0, 0));
        step("D.lk",    0, 1, 0, '0,          0, 0, mk(RUN_L, PRE,         1, 0, 0, 0, 0));
        lock_run("D", ARMED, 28'h0000123);
        step("D.start", 0, 0, 0, '0,          1, 0, mk(RUN_U, 28'h0000123, 0, 0, 0, 0, 0));

        // Reset mid-countdown: immediate IDLE, no done pulse.
        do_reset("rstE");
        step("E.load",  0, 0, 1, 28'h0000002, 0, 0, mk(ARMED, 28'h0000002, 0, 1, 0, 0, 0));
        step("E.start", 0, 0, 0, '0,          1, 0, mk(RUN_U, 28'h0000002, 0, 0, 0, 0, 0));
        step("E.tick",  1, 0, 0, '0,          0, 0, mk(RUN_U, 28'h0000001, 0, 0, 0, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        check_obs("E.async", mk(IDLE, '0, 0, 0, 0, 0, 0));
        bus.tick = 1'b1;
        @(posedge clk); #1;
        check_obs("E.held", mk(IDLE, '0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        bus.tick = 1'b0;
        step("E.post", 1, 0, 0, '0, 0, 0, mk(IDLE, '0, 0, 0, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
